// File: rtl/bus_pkg.sv
// Shared types and constants for the PE bus responder and its arbiter.
package bus_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [DATA_W-1:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    CAPTURE,
    RREAD,
    MEM,
    DONE
  } state_e;

  // Command fields still needed after the capture cycle.
  typedef struct packed {
    logic              is_mem;
    logic              mem_we;
    logic              exec;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] pc;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index strictly above the
// pointer, wrapping modulo NUM_PE.
module rr_arbiter #(
  parameter  int NUM_PE = 4,
  localparam int IDX_W  = $clog2(NUM_PE)
) (
  input  logic [NUM_PE-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_PE-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_PE; i++) begin
      cand = IDX_W'((32'(ptr_i) + 32'(i)) % 32'(NUM_PE));
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Target end of the PE shared bus: grants one initiator at a time, services its
// register-file, global-memory and completion commands, and returns one-cycle responses.
module bus_responder
  import bus_pkg::*;
#(
  parameter int                NUM_PE      = 4,
  parameter int                MEM_TIMEOUT = 64,
  parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PE-1:0]         bus_request,
  output logic [NUM_PE-1:0]         grant,
  input  logic [DATA_W-1:0]         mem_addressBus,
  input  logic [DATA_W-1:0]         result_outBus,
  input  logic [DATA_W-1:0]         PCoutBus,
  input  logic [REG_ADDR_W-1:0]     rs1OutBus,
  input  logic [REG_ADDR_W-1:0]     rs2OutBus,
  input  logic [REG_ADDR_W-1:0]     rdOutBus,
  input  logic                      reg_selectBus,
  input  logic                      mem_readBus,
  input  logic                      mem_writeBus,
  input  logic                      rd_writeBus,
  input  logic                      read_enBus,
  input  logic                      execution_completeBus,
  input  logic [DATA_W-1:0]         data_Store,
  output logic [DATA_W-1:0]         AmuxBus,
  output logic [DATA_W-1:0]         BmuxBus,
  output logic                      data_ReadyBus,
  output logic [DATA_W-1:0]         memData,
  output logic                      mem_ackBus,
  output logic                      gm_req,
  output logic                      gm_we,
  output logic [DATA_W-1:0]         gm_addr,
  output logic [DATA_W-1:0]         gm_wdata,
  input  logic [DATA_W-1:0]         gm_rdata,
  input  logic                      gm_ready,
  output logic                      done_valid,
  output logic [$clog2(NUM_PE)-1:0] done_pe,
  output logic [DATA_W-1:0]         done_pc,
  output logic [DATA_W-1:0]         done_result,
  output logic                      bus_error
);

  localparam int IDX_W = $clog2(NUM_PE);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [NUM_PE-1:0]   gnt_q, gnt_d;
  cmd_t                cmd_q, cmd_d, cmd_in;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   amux_q, amux_d;
  logic [DATA_W-1:0]   bmux_q, bmux_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic                rf_we;
  logic [DATA_W-1:0]   rs1_val, rs2_val;

  logic [NUM_PE-1:0]   arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic                req_held;

  rr_arbiter #(.NUM_PE(NUM_PE)) u_arb (
    .req_i   (bus_request),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // A winner that dropped its request before its grant cycle is not granted.
  assign req_held = |(bus_request & gnt_q);

  always_comb begin
    cmd_in        = '0;
    cmd_in.is_mem = mem_readBus | mem_writeBus;
    cmd_in.mem_we = mem_writeBus;
    cmd_in.exec   = execution_completeBus;
    cmd_in.addr   = mem_addressBus;
    cmd_in.result = result_outBus;
    cmd_in.pc     = PCoutBus;
  end

  // Register file: the write lands at the end of CAPTURE; x0 is never written.
  assign rf_we = (state_q == CAPTURE) && rd_writeBus && (rdOutBus != '0);

  // NOTE: the register file is reset because a cleared file is architecturally
  // visible; that choice keeps it in flops rather than an unresettable RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[rdOutBus] <= data_Store;
    end
  end

  // Read ports with write-first bypass so a same-transaction write is seen.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1OutBus != '0) begin
      rs1_val = (rf_we && (rdOutBus == rs1OutBus)) ? data_Store : rf_q[rs1OutBus];
    end
    if (rs2OutBus != '0) begin
      rs2_val = (rf_we && (rdOutBus == rs2OutBus)) ? data_Store : rf_q[rs2OutBus];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    amux_d     = amux_q;
    bmux_d     = bmux_q;
    mem_data_d = mem_data_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_d   = arb_idx;
          gnt_d   = arb_gnt;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (req_held) begin
          ptr_d   = win_q;
          state_d = CAPTURE;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        cmd_d = cmd_in;
        cnt_d = '0;
        err_d = 1'b0;
        if (read_enBus) begin
          amux_d  = rs1_val;
          bmux_d  = reg_selectBus ? rs2_val : '0;
          state_d = RREAD;
        end else if (cmd_in.is_mem) begin
          state_d = MEM;
        end else if (cmd_in.exec) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RREAD: begin
        state_d = cmd_q.is_mem ? MEM : IDLE;
      end
      MEM: begin
        if (gm_ready) begin
          mem_data_d = cmd_q.mem_we ? '0 : gm_rdata;
          state_d    = DONE;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          mem_data_d = ERR_DATA;
          err_d      = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(NUM_PE - 1);
      win_q      <= '0;
      gnt_q      <= '0;
      cmd_q      <= '0;
      cnt_q      <= '0;
      amux_q     <= '0;
      bmux_q     <= '0;
      mem_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      amux_q     <= amux_d;
      bmux_q     <= bmux_d;
      mem_data_q <= mem_data_d;
      err_q      <= err_d;
    end
  end

  assign grant         = ((state_q == GRANT) && req_held) ? gnt_q : '0;
  assign data_ReadyBus = (state_q == RREAD);
  assign AmuxBus       = amux_q;
  assign BmuxBus       = bmux_q;
  assign memData       = mem_data_q;
  assign mem_ackBus    = (state_q == DONE) && cmd_q.is_mem;
  assign bus_error     = mem_ackBus && err_q;
  assign gm_req        = (state_q == MEM);
  assign gm_we         = cmd_q.mem_we;
  assign gm_addr       = cmd_q.addr;
  assign gm_wdata      = cmd_q.result;

  // Completion rides on the last service cycle: DONE, or RREAD when no memory op follows.
  assign done_valid  = cmd_q.exec &&
                       ((state_q == DONE) || ((state_q == RREAD) && !cmd_q.is_mem));
  assign done_pe     = win_q;
  assign done_pc     = cmd_q.pc;
  assign done_result = cmd_q.result;

endmodule

// File: tb/tb_bus_responder.sv
// Scenario-driven bench for bus_responder with a queue of expected responses.
module tb_bus_responder;

  localparam int NUM_PE = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_PE-1:0] bus_request;
  logic [NUM_PE-1:0] grant;
  logic [31:0]       mem_addressBus, result_outBus, PCoutBus;
  logic [4:0]        rs1OutBus, rs2OutBus, rdOutBus;
  logic              reg_selectBus, mem_readBus, mem_writeBus, rd_writeBus;
  logic              read_enBus, execution_completeBus;
  logic [31:0]       data_Store;
  logic [31:0]       AmuxBus, BmuxBus, memData;
  logic              data_ReadyBus, mem_ackBus;
  logic              gm_req, gm_we;
  logic [31:0]       gm_addr, gm_wdata, gm_rdata;
  logic              gm_ready;
  logic              done_valid;
  logic [1:0]        done_pe;
  logic [31:0]       done_pc, done_result;
  logic              bus_error;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  bus_responder #(.NUM_PE(NUM_PE), .MEM_TIMEOUT(64), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset), .bus_request(bus_request), .grant(grant),
    .mem_addressBus(mem_addressBus), .result_outBus(result_outBus), .PCoutBus(PCoutBus),
    .rs1OutBus(rs1OutBus), .rs2OutBus(rs2OutBus), .rdOutBus(rdOutBus),
    .reg_selectBus(reg_selectBus), .mem_readBus(mem_readBus), .mem_writeBus(mem_writeBus),
    .rd_writeBus(rd_writeBus), .read_enBus(read_enBus),
    .execution_completeBus(execution_completeBus), .data_Store(data_Store),
    .AmuxBus(AmuxBus), .BmuxBus(BmuxBus), .data_ReadyBus(data_ReadyBus),
    .memData(memData), .mem_ackBus(mem_ackBus),
    .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
    .gm_rdata(gm_rdata), .gm_ready(gm_ready),
    .done_valid(done_valid), .done_pe(done_pe), .done_pc(done_pc),
    .done_result(done_result), .bus_error(bus_error)
  );

  typedef struct {
    int          pe;
    bit          wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          sel;
    logic [31:0] ea;
    logic [31:0] eb;
  } reg_txn_t;

  task automatic clear_bus();
    mem_addressBus = '0; result_outBus = '0; PCoutBus = '0;
    rs1OutBus = '0; rs2OutBus = '0; rdOutBus = '0; data_Store = '0;
    reg_selectBus = 1'b0; mem_readBus = 1'b0; mem_writeBus = 1'b0;
    rd_writeBus = 1'b0; read_enBus = 1'b0; execution_completeBus = 1'b0;
  endtask

  // Raises the request and returns at the negedge inside the grant cycle, request still high.
  task automatic request_and_wait(input int pe, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus_request[pe] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (grant[pe]) begin
        ok = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!ok) begin
      $display("FAIL grant_wait pe%0d: grant=%b, required grant bit %0d within 20 cycles", pe, grant, pe);
      bus_request[pe] = 1'b0;
    end else pass_cnt++;
  endtask

  // Acts as global memory: asserts gm_ready in the ready_after-th gm_req cycle (0 = never).
  task automatic wait_mem_ack(input int ready_after, input logic [31:0] rdata,
                              output int req_cycles, output bit acked);
    req_cycles = 0;
    acked      = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      gm_ready = 1'b0;
      if (mem_ackBus) begin
        acked = 1'b1;
        break;
      end
      if (gm_req) begin
        req_cycles++;
        if (req_cycles == ready_after) begin
          gm_ready = 1'b1;
          gm_rdata = rdata;
        end
      end
    end
    gm_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++; if (grant !== 4'h0) $display("FAIL reset_grant: got %b, required 0", grant); else pass_cnt++;
    total_cnt++; if (data_ReadyBus !== 1'b0) $display("FAIL reset_ready: got %b, required 0", data_ReadyBus); else pass_cnt++;
    total_cnt++; if (mem_ackBus !== 1'b0) $display("FAIL reset_ack: got %b, required 0", mem_ackBus); else pass_cnt++;
    total_cnt++; if (gm_req !== 1'b0) $display("FAIL reset_gm_req: got %b, required 0", gm_req); else pass_cnt++;
    total_cnt++; if (done_valid !== 1'b0) $display("FAIL reset_done: got %b, required 0", done_valid); else pass_cnt++;
    total_cnt++; if (bus_error !== 1'b0) $display("FAIL reset_err: got %b, required 0", bus_error); else pass_cnt++;
    total_cnt++; if (AmuxBus !== 32'h0) $display("FAIL reset_amux: got %h, required 0", AmuxBus); else pass_cnt++;
    total_cnt++; if (memData !== 32'h0) $display("FAIL reset_memdata: got %h, required 0", memData); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (grant !== 4'h0) $display("FAIL idle_grant: got %b, required 0", grant); else pass_cnt++;
  endtask

  task automatic test_reg_file();
    reg_txn_t    tbl [4];
    bit          ok;
    logic [31:0] ea, eb;
    tbl[0] = '{1, 1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd0, 1'b1, 32'h0000_1234, 32'h0};
    tbl[1] = '{2, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0000_1234};
    tbl[2] = '{3, 1'b0, 5'd0, 32'h0,         5'd0, 5'd5, 1'b0, 32'h0, 32'h0};
    tbl[3] = '{0, 1'b1, 5'd7, 32'hAAAA_5555, 5'd5, 5'd7, 1'b1, 32'h0000_1234, 32'hAAAA_5555};
    for (int t = 0; t < 4; t++) begin
      request_and_wait(tbl[t].pe, ok);
      if (!ok) return;
      rd_writeBus = tbl[t].wr; rdOutBus = tbl[t].rd; data_Store = tbl[t].data;
      read_enBus = 1'b1; rs1OutBus = tbl[t].rs1; rs2OutBus = tbl[t].rs2; reg_selectBus = tbl[t].sel;
      exp_q.push_back(tbl[t].ea);
      exp_q.push_back(tbl[t].eb);
      @(negedge clk);
      bus_request = '0;
      total_cnt++; if (data_ReadyBus !== 1'b0) $display("FAIL rf%0d_ready_early: got %b, required 0", t, data_ReadyBus); else pass_cnt++;
      @(negedge clk);
      clear_bus();
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      total_cnt++; if (data_ReadyBus !== 1'b1) $display("FAIL rf%0d_ready: got %b, required 1 at grant+2", t, data_ReadyBus); else pass_cnt++;
      total_cnt++; if (AmuxBus !== ea) $display("FAIL rf%0d_amux: got %h, required %h", t, AmuxBus, ea); else pass_cnt++;
      total_cnt++; if (BmuxBus !== eb) $display("FAIL rf%0d_bmux: got %h, required %h", t, BmuxBus, eb); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (data_ReadyBus !== 1'b0 || AmuxBus !== ea) $display("FAIL rf%0d_pulse_hold: ready=%b amux=%h, required 0 and %h", t, data_ReadyBus, AmuxBus, ea); else pass_cnt++;
    end
  endtask

  task automatic test_mem_read();
    bit ok, acked;
    int nreq;
    logic [31:0] e;
    request_and_wait(0, ok);
    if (!ok) return;
    mem_readBus = 1'b1; mem_addressBus = 32'h100;
    exp_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    bus_request = '0;
    wait_mem_ack(3, 32'hCAFE_F00D, nreq, acked);
    clear_bus();
    e = exp_q.pop_front();
    total_cnt++; if (!acked) $display("FAIL mrd_ack_timeout: no mem_ackBus, required one"); else pass_cnt++;
    total_cnt++; if (nreq !== 3) $display("FAIL mrd_req_cycles: got %0d, required 3", nreq); else pass_cnt++;
    total_cnt++; if (gm_req !== 1'b0) $display("FAIL mrd_req_drop: got %b, required 0", gm_req); else pass_cnt++;
    total_cnt++; if (memData !== e) $display("FAIL mrd_data: got %h, required %h", memData, e); else pass_cnt++;
    total_cnt++; if (gm_addr !== 32'h100 || gm_we !== 1'b0) $display("FAIL mrd_addr_we: got %h/%b, required 00000100/0", gm_addr, gm_we); else pass_cnt++;
    total_cnt++; if (bus_error !== 1'b0) $display("FAIL mrd_err: got %b, required 0", bus_error); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (mem_ackBus !== 1'b0 || memData !== e) $display("FAIL mrd_pulse_hold: ack=%b data=%h, required 0 and %h", mem_ackBus, memData, e); else pass_cnt++;
  endtask

  task automatic test_mem_timeout();
    bit ok, acked;
    int nreq;
    logic [31:0] e;
    request_and_wait(1, ok);
    if (!ok) return;
    mem_writeBus = 1'b1; mem_addressBus = 32'h200; result_outBus = 32'h55;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    bus_request = '0;
    wait_mem_ack(0, 32'h0, nreq, acked);
    clear_bus();
    e = exp_q.pop_front();
    total_cnt++; if (!acked) $display("FAIL tmo_ack: no mem_ackBus, required one"); else pass_cnt++;
    total_cnt++; if (nreq !== 64) $display("FAIL tmo_req_cycles: got %0d, required 64", nreq); else pass_cnt++;
    total_cnt++; if (gm_req !== 1'b0) $display("FAIL tmo_req_drop: got %b, required 0", gm_req); else pass_cnt++;
    total_cnt++; if (bus_error !== 1'b1) $display("FAIL tmo_err: got %b, required 1", bus_error); else pass_cnt++;
    total_cnt++; if (memData !== e) $display("FAIL tmo_data: got %h, required %h", memData, e); else pass_cnt++;
    total_cnt++; if (gm_we !== 1'b1 || gm_wdata !== 32'h55) $display("FAIL tmo_we_wdata: got %b/%h, required 1/00000055", gm_we, gm_wdata); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus_error !== 1'b0 || mem_ackBus !== 1'b0) $display("FAIL tmo_pulse: err=%b ack=%b, required 0/0", bus_error, mem_ackBus); else pass_cnt++;
  endtask

  task automatic test_exec_complete();
    bit ok;
    request_and_wait(2, ok);
    if (!ok) return;
    execution_completeBus = 1'b1; PCoutBus = 32'h40; result_outBus = 32'd7;
    @(negedge clk);
    bus_request = '0;
    @(negedge clk);
    clear_bus();
    total_cnt++; if (done_valid !== 1'b1) $display("FAIL exec_valid: got %b, required 1", done_valid); else pass_cnt++;
    total_cnt++; if (done_pe !== 2'd2) $display("FAIL exec_pe: got %0d, required 2", done_pe); else pass_cnt++;
    total_cnt++; if (done_pc !== 32'h40 || done_result !== 32'd7) $display("FAIL exec_pc_res: got %h/%h, required 00000040/00000007", done_pc, done_result); else pass_cnt++;
    total_cnt++; if (mem_ackBus !== 1'b0 || data_ReadyBus !== 1'b0) $display("FAIL exec_no_resp: ack=%b ready=%b, required 0/0", mem_ackBus, data_ReadyBus); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done_valid !== 1'b0) $display("FAIL exec_pulse: got %b, required 0", done_valid); else pass_cnt++;
  endtask

  // Read, memory (read+write, write wins) and completion in one transaction.
  task automatic test_back_to_back();
    bit ok, acked;
    int nreq;
    logic [31:0] ea, eb, em;
    request_and_wait(3, ok);
    if (!ok) return;
    read_enBus = 1'b1; rs1OutBus = 5'd5; rs2OutBus = 5'd7; reg_selectBus = 1'b1;
    mem_readBus = 1'b1; mem_writeBus = 1'b1; mem_addressBus = 32'h300; result_outBus = 32'h99;
    execution_completeBus = 1'b1; PCoutBus = 32'h80;
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'hAAAA_5555);
    exp_q.push_back(32'h0);
    @(negedge clk);
    bus_request = '0;
    @(negedge clk);
    clear_bus();
    ea = exp_q.pop_front();
    eb = exp_q.pop_front();
    total_cnt++; if (data_ReadyBus !== 1'b1 || AmuxBus !== ea || BmuxBus !== eb) $display("FAIL b2b_read: ready=%b a=%h b=%h, required 1 %h %h", data_ReadyBus, AmuxBus, BmuxBus, ea, eb); else pass_cnt++;
    total_cnt++; if (mem_ackBus !== 1'b0 || done_valid !== 1'b0) $display("FAIL b2b_overlap: ack=%b done=%b, required 0/0", mem_ackBus, done_valid); else pass_cnt++;
    wait_mem_ack(1, 32'h1234_5678, nreq, acked);
    em = exp_q.pop_front();
    total_cnt++; if (!acked || nreq !== 1) $display("FAIL b2b_ack: acked=%b req_cycles=%0d, required 1/1", acked, nreq); else pass_cnt++;
    total_cnt++; if (gm_we !== 1'b1 || gm_wdata !== 32'h99) $display("FAIL b2b_write_wins: we=%b wdata=%h, required 1/00000099", gm_we, gm_wdata); else pass_cnt++;
    total_cnt++; if (memData !== em) $display("FAIL b2b_memdata: got %h, required %h", memData, em); else pass_cnt++;
    total_cnt++; if (done_valid !== 1'b1 || done_pe !== 2'd3 || done_pc !== 32'h80) $display("FAIL b2b_done: v=%b pe=%0d pc=%h, required 1 3 00000080", done_valid, done_pe, done_pc); else pass_cnt++;
    total_cnt++; if (data_ReadyBus !== 1'b0 || AmuxBus !== ea) $display("FAIL b2b_amux_hold: ready=%b a=%h, required 0 %h", data_ReadyBus, AmuxBus, ea); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int ngr;
    logic [31:0] e;
    logic [NUM_PE-1:0] oh;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_bus();
    for (int p = 0; p < 5; p++) exp_q.push_back(32'(p % NUM_PE));
    bus_request = '1;
    ngr = 0;
    for (int k = 0; k < 100 && ngr < 5; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        e = exp_q.pop_front();
        ngr++;
        oh = '0;
        oh[e[1:0]] = 1'b1;
        total_cnt++; if (grant !== oh) $display("FAIL rr_grant%0d: got %b, required %b", ngr, grant, oh); else pass_cnt++;
      end
    end
    bus_request = '0;
    total_cnt++; if (ngr !== 5) $display("FAIL rr_count: got %0d grants, required 5 within 100 cycles", ngr); else pass_cnt++;
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    bit ok;
    int nack;
    request_and_wait(2, ok);
    if (!ok) return;
    mem_readBus = 1'b1; mem_addressBus = 32'h400;
    @(negedge clk);
    bus_request = '0;
    @(negedge clk);
    total_cnt++; if (gm_req !== 1'b1) $display("FAIL rst_mem_req: got %b, required 1 before reset", gm_req); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (gm_req !== 1'b0) $display("FAIL rst_async_req: got %b, required 0 immediately", gm_req); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    clear_bus();
    nack = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ackBus) nack++;
    end
    total_cnt++; if (nack !== 0) $display("FAIL rst_no_ack: got %0d acks, required 0", nack); else pass_cnt++;
    request_and_wait(1, ok);
    if (!ok) return;
    read_enBus = 1'b1; rs1OutBus = 5'd5;
    exp_q.push_back(32'h0);
    @(negedge clk);
    bus_request = '0;
    @(negedge clk);
    clear_bus();
    total_cnt++; if (data_ReadyBus !== 1'b1 || AmuxBus !== exp_q[0]) $display("FAIL rst_rf_cleared: ready=%b a=%h, required 1 %h", data_ReadyBus, AmuxBus, exp_q[0]); else pass_cnt++;
    void'(exp_q.pop_front());
  endtask

  initial begin
    reset       = 1'b1;
    bus_request = '0;
    gm_ready    = 1'b0;
    gm_rdata    = '0;
    clear_bus();
    test_reset();
    test_reg_file();
    test_mem_read();
    test_mem_timeout();
    test_exec_complete();
    test_back_to_back();
    test_round_robin();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target end of the PE shared bus: arbitrates among NUM_PE bus interface initiators and grants one at a time.
- Captures the granted PE's command strobes and services them: register-file write/read, global-memory read/write, execution-complete/PC forwarding to controller.
- Returns the response (AmuxBus/BmuxBus + data_ReadyBus, or memData + mem_ackBus) as a one-cycle pulse.
- Owns the 32x32 shared register file (local memory); x0 reads zero.

Parameters:
NUM_PE, 4, number of requesting PEs (>=2)
MEM_TIMEOUT, 64, max cycles waiting for gm_ready before error
ERR_DATA, 32'hDEAD_BEEF, memData returned on memory timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
bus_request  in  NUM_PE  per-PE request
grant  out  NUM_PE  one-hot, one-cycle grant pulse
mem_addressBus  in  32  global memory address
result_outBus  in  32  store data / completion result
PCoutBus  in  32  PE program counter
rs1OutBus, rs2OutBus, rdOutBus  in  5 each  register selects
reg_selectBus  in  1  1 = read rs1 and rs2, 0 = rs1 only
mem_readBus, mem_writeBus, rd_writeBus, read_enBus, execution_completeBus  in  1 each  command strobes
data_Store  in  32  register write data
AmuxBus, BmuxBus  out  32 each  register read data
data_ReadyBus  out  1  register read response pulse
memData  out  32  global memory read data
mem_ackBus  out  1  memory response pulse
gm_req  out  1  memory request, held until gm_ready
gm_we  out  1  1 = write
gm_addr, gm_wdata  out  32 each  memory address/data
gm_rdata  in  32  memory read data
gm_ready  in  1  memory completion, single cycle
done_valid  out  1  completion pulse to controller
done_pe  out  $clog2(NUM_PE)  completing PE index
done_pc, done_result  out  32 each  PC / result of completing PE
bus_error  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (async): all outputs 0.
  - FSM returns to IDLE; arbiter pointer set to NUM_PE-1 so PE0 wins first; register file cleared.
  - Reset mid-transaction aborts without any response pulse.
- FSM states:
  - IDLE: on any bus_request, pick the winner -> GRANT.
  - GRANT: grant[winner]=1 for exactly one cycle; pointer <= winner -> CAPTURE.
  - CAPTURE: one cycle after the grant, sample all bus inputs into holding registers.
    - No strobe set -> IDLE with no response.
- Servicing order within a transaction (multiple strobes allowed):
  - rd_write: the write to rf[rdOutBus] is committed in CAPTURE. Writes to x0 are ignored.
  - read_en -> RREAD (1 cycle): AmuxBus=rf[rs1], BmuxBus = reg_select ? rf[rs2] : 0; data_ReadyBus=1.
    - A same-transaction rd_write is visible (write-first).
  - mem_read or mem_write -> MEM: gm_req=1 with gm_we=mem_write, gm_addr=mem_addressBus, gm_wdata=result_outBus.
    - On gm_ready: drop gm_req; memData=gm_rdata (reads) or 0 (writes); mem_ackBus=1 for 1 cycle.
    - If both mem_read and mem_write are set, the write wins.
  - Memory timeout: the counter reaches MEM_TIMEOUT with no gm_ready -> drop gm_req, memData=ERR_DATA, mem_ackBus=1, bus_error=1.
  - execution_complete: done_valid=1 for 1 cycle with done_pe, done_pc, done_result, emitted in the final service cycle.
  - Then -> IDLE. The next grant comes no earlier than 1 cycle after IDLE.
- Response pulses never overlap: a read+mem transaction gives data_ReadyBus first, then mem_ackBus at least 1 cycle later.
  - AmuxBus/BmuxBus/memData hold their value until the next response.
- Round-robin arbitration: the winner is the lowest index strictly above the pointer, wrapping modulo NUM_PE. Requests that drop before GRANT are ignored.
- Latencies:
  - Request to grant: 1 cycle from IDLE.
  - Register read response: grant + 2 cycles.
  - Memory response: gm_ready + 1 cycle.

Decomposition:
- Shared package bus_pkg: state enum (IDLE, GRANT, CAPTURE, RREAD, MEM, DONE), ERR_DATA default, REG_ADDR_W=5, DATA_W=32.
- Sub-module rr_arbiter: NUM_PE request vector + pointer -> one-hot winner and index; purely combinational, pointer held in bus_responder.

Test Plan:
- PE1 rd_write rd=5 data=32'h1234, read_en rs1=5 rs2=0 reg_select=1 -> data_ReadyBus at grant+2, AmuxBus=32'h1234, BmuxBus=0.
- rd_write rd=0 data=32'hFFFF_FFFF, then read rs1=0 -> AmuxBus=0.
- PE0 mem_read addr=32'h100, gm_ready after 3 cycles with gm_rdata=32'hCAFE_F00D -> gm_req high 3 cycles, mem_ackBus pulse, memData=32'hCAFE_F00D.
- All 4 PEs request continuously -> grants in order 0,1,2,3,0; each PE granted within 4 transactions.
- mem_write with gm_ready never asserted -> after 64 cycles gm_req=0, mem_ackBus=1, bus_error=1, memData=32'hDEAD_BEEF.
- execution_complete from PE2 with PC=32'h40 result=7 -> done_valid 1 cycle, done_pe=2, done_pc=32'h40, done_result=7; reset asserted mid-MEM -> gm_req=0 immediately, no ack.
